// File: rtl/banco_reg_pkg.sv
// rtl/banco_reg_pkg.sv - shared types and constants for the RTC register bank
//
// Purpose : state encoding of the capture sequencer, default bank geometry
//           and the RTC field address map.
// Ports   : none (package).
package banco_reg_pkg;

   localparam int N_REG_DEF = 9;
   localparam int ANCHO_DEF = 8;

   typedef enum logic [1:0] {
      REPOSO  = 2'd0,
      BARRIDO = 2'd1,
      FIN     = 2'd2
   } estado_t;

   localparam logic [3:0] DIR_SEG      = 4'd0;
   localparam logic [3:0] DIR_MIN      = 4'd1;
   localparam logic [3:0] DIR_HORA     = 4'd2;
   localparam logic [3:0] DIR_DIA      = 4'd3;
   localparam logic [3:0] DIR_MES      = 4'd4;
   localparam logic [3:0] DIR_ANO      = 4'd5;
   localparam logic [3:0] DIR_SEG_TMR  = 4'd6;
   localparam logic [3:0] DIR_MIN_TMR  = 4'd7;
   localparam logic [3:0] DIR_HORA_TMR = 4'd8;

endpackage

// File: rtl/bcd_valido.sv
// rtl/bcd_valido.sv - combinational packed-BCD validity check
//
// Purpose : flags a byte as valid BCD when every nibble is 0..9.
// Ports   : dato   in  ANCHO  byte under test
//           valido out 1      1 when all nibbles are <= 9
module bcd_valido #(
   parameter int ANCHO = 8
) (
   input  logic [ANCHO-1:0] dato,
   output logic             valido
);

   always_comb begin
      valido = 1'b1;
      for (int n = 0; n < ANCHO / 4; n++) begin
         if (dato[4*n +: 4] > 4'd9) begin
            valido = 1'b0;
         end
      end
   end

endmodule

// File: rtl/banco_reg_rtc.sv
// rtl/banco_reg_rtc.sv - RTC time/date register bank with capture sequencer
//
// Purpose : on iniciar, sweeps selector 0..N_REG-1 and stores each byte from
//           the field mux; accepts single-byte external edits while idle and
//           serves a registered read port.
// Config  : BANCO_BCD_CHECK_EN - reject non-BCD writes and raise sticky
//           error_bcd; undefined: writes stored unchecked, error_bcd = 0.
// Ports   : clk, rst_n              clock, synchronous active-low reset
//           iniciar                 start-sweep request (idle only)
//           dato_reg  / selector    field mux data in / address out
//           ocupado, listo          busy level, sweep-complete pulse
//           we_ext, dir_ext, dato_ext  external single-byte write
//           dir_lect / dato_lect    read address / registered read data
//           error_bcd               sticky BCD error flag
module banco_reg_rtc
   import banco_reg_pkg::*;
#(
   parameter int N_REG = N_REG_DEF,
   parameter int ANCHO = ANCHO_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             iniciar,
   input  logic [ANCHO-1:0] dato_reg,
   output logic [3:0]       selector,
   output logic             ocupado,
   output logic             listo,
   input  logic             we_ext,
   input  logic [3:0]       dir_ext,
   input  logic [ANCHO-1:0] dato_ext,
   input  logic [3:0]       dir_lect,
   output logic [ANCHO-1:0] dato_lect,
   output logic             error_bcd
);

   localparam logic [3:0] DIR_ULTIMA = 4'(N_REG - 1);

   estado_t          estado_q,    estado_d;
   logic [3:0]       contador_q,  contador_d;
   logic             ocupado_q,   ocupado_d;
   logic             listo_q,     listo_d;
   logic [ANCHO-1:0] dato_lect_q, dato_lect_d;
   logic [ANCHO-1:0] banco_q [N_REG];
   logic [ANCHO-1:0] banco_d [N_REG];

   // Single write port shared by the sweep and external edits; the FSM state
   // decides who owns it, so the two sources can never collide.
   logic             wr_en;
   logic [3:0]       wr_dir;
   logic [ANCHO-1:0] wr_dato;
   logic             wr_valido;

   always_comb begin
      wr_en   = 1'b0;
      wr_dir  = 4'd0;
      wr_dato = '0;
      case (estado_q)
         BARRIDO: begin
            wr_en   = 1'b1;
            wr_dir  = contador_q;
            wr_dato = dato_reg;
         end
         REPOSO: begin
            if (we_ext && (dir_ext <= DIR_ULTIMA)) begin
               wr_en   = 1'b1;
               wr_dir  = dir_ext;
               wr_dato = dato_ext;
            end
         end
         default: ;
      endcase
   end

`ifdef BANCO_BCD_CHECK_EN
   logic error_bcd_q, error_bcd_d;

   bcd_valido #(.ANCHO(ANCHO)) u_bcd_valido (
      .dato   (wr_dato),
      .valido (wr_valido)
   );

   // Accepting iniciar clears the flag; a rejected write in the same cycle
   // (external edit alongside iniciar) still sets it.
   always_comb begin
      error_bcd_d = error_bcd_q;
      if ((estado_q == REPOSO) && iniciar) begin
         error_bcd_d = 1'b0;
      end
      if (wr_en && !wr_valido) begin
         error_bcd_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         error_bcd_q <= 1'b0;
      end else begin
         error_bcd_q <= error_bcd_d;
      end
   end

   assign error_bcd = error_bcd_q;
`else
   assign wr_valido = 1'b1;
   assign error_bcd = 1'b0;
`endif

   // Sequencer. The counter doubles as the selector: it is held at 0 outside
   // BARRIDO so selector reads 0 in REPOSO and FIN without extra decode.
   always_comb begin
      estado_d   = estado_q;
      contador_d = contador_q;
      case (estado_q)
         REPOSO: begin
            if (iniciar) begin
               estado_d   = BARRIDO;
               contador_d = 4'd0;
            end
         end
         BARRIDO: begin
            if (contador_q == DIR_ULTIMA) begin
               estado_d   = FIN;
               contador_d = 4'd0;
            end else begin
               contador_d = contador_q + 4'd1;
            end
         end
         FIN: begin
            estado_d   = REPOSO;
            contador_d = 4'd0;
         end
         default: begin
            estado_d   = REPOSO;
            contador_d = 4'd0;
         end
      endcase
      ocupado_d = (estado_d != REPOSO);
      listo_d   = (estado_d == FIN);
   end

   always_comb begin
      for (int i = 0; i < N_REG; i++) begin
         banco_d[i] = banco_q[i];
         if (wr_en && wr_valido && (wr_dir == 4'(i))) begin
            banco_d[i] = wr_dato;
         end
      end
   end

   // Read uses the pre-write contents, so a same-cycle write is seen next read.
   always_comb begin
      dato_lect_d = '0;
      if (dir_lect <= DIR_ULTIMA) begin
         dato_lect_d = banco_q[dir_lect];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado_q    <= REPOSO;
         contador_q  <= 4'd0;
         ocupado_q   <= 1'b0;
         listo_q     <= 1'b0;
         dato_lect_q <= '0;
         for (int i = 0; i < N_REG; i++) begin
            banco_q[i] <= '0;
         end
      end else begin
         estado_q    <= estado_d;
         contador_q  <= contador_d;
         ocupado_q   <= ocupado_d;
         listo_q     <= listo_d;
         dato_lect_q <= dato_lect_d;
         for (int i = 0; i < N_REG; i++) begin
            banco_q[i] <= banco_d[i];
         end
      end
   end

   assign selector  = contador_q;
   assign ocupado   = ocupado_q;
   assign listo     = listo_q;
   assign dato_lect = dato_lect_q;

endmodule
